// File: rtl/panda_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : panda_if_stage
//  Purpose  : Instruction-fetch stage. Issues word-aligned fetch requests
//             under a two-slot credit budget, buffers returned instructions
//             in a 2-entry {instr, pc} FIFO that forms the IF/ID register,
//             and drops responses made stale by a branch/jump redirect.
//  Ports    : clk_i, rst_i (async, active-high)
//             instr_req_o / instr_addr_o / instr_gnt_i         request channel
//             instr_rvalid_i / instr_rdata_i                   in-order response
//             redirect_i / redirect_addr_i                     flush + new target
//             ready_i / valid_o / instr_o / pc_o / pc_inc_o    IF/ID handshake
//  Revision : 1.0  initial release
// ============================================================================
module panda_if_stage #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_inc_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic [1:0]  state_q,      state_d;
   logic [31:0] fetch_pc_q,   fetch_pc_d;
   logic [31:0] hold_addr_q,  hold_addr_d;
   logic        hold_redir_q, hold_redir_d;
   logic [1:0]  out_cnt_q,    out_cnt_d;
   logic [1:0]  discard_q,    discard_d;
   logic [1:0]  fifo_cnt_q,   fifo_cnt_d;
   logic        rd_ptr_q,     rd_ptr_d;
   logic        wr_ptr_q,     wr_ptr_d;
   logic [31:0] fifo_instr_q [2];
   logic [31:0] fifo_instr_d [2];
   logic [31:0] fifo_pc_q    [2];
   logic [31:0] fifo_pc_d    [2];

   logic        credit_ok;
   logic        granted;
   logic        drop;
   logic        late_drop;
   logic        push;
   logic        pop;
   logic [31:0] push_pc;
   logic [31:0] head_pc;

   // Credit uses registered counts only: a pop in this cycle does not free
   // a slot until the next one, which bounds outstanding + buffered to 2.
   assign credit_ok    = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < 3'd2;
   assign instr_req_o  = ((state_q == ST_RUN) && credit_ok) || (state_q == ST_HOLD);
   // While held, the address is frozen even if a redirect reloads fetch_pc.
   assign instr_addr_o = (state_q == ST_HOLD) ? hold_addr_q : fetch_pc_q;
   assign granted      = instr_req_o && instr_gnt_i;

   // A held request whose target was superseded by a redirect becomes a
   // discard only once it is actually granted.
   assign late_drop = granted && (state_q == ST_HOLD) && hold_redir_q;
   assign drop      = instr_rvalid_i && (discard_q != 2'd0);
   assign push      = instr_rvalid_i && (discard_q == 2'd0) && !redirect_i;
   assign valid_o   = (fifo_cnt_q != 2'd0);
   assign pop       = valid_o && ready_i && !redirect_i;

   // With nothing pending discard, every outstanding request was issued
   // contiguously from fetch_pc backwards, so the oldest one (the one now
   // returning) sits out_cnt words behind fetch_pc.
   assign push_pc = fetch_pc_q - {28'd0, out_cnt_q, 2'b00};

   assign head_pc  = fifo_pc_q[rd_ptr_q];
   assign instr_o  = valid_o ? fifo_instr_q[rd_ptr_q] : 32'd0;
   assign pc_o     = valid_o ? head_pc : 32'd0;
   assign pc_inc_o = valid_o ? (head_pc + 32'd4) : 32'd0;

   // Fetch control: state, fetch PC, hold bookkeeping, request counters.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      hold_addr_d  = hold_addr_q;
      hold_redir_d = 1'b0;
      out_cnt_d    = out_cnt_q + {1'b0, granted} - {1'b0, instr_rvalid_i};
      discard_d    = discard_q - {1'b0, drop} + {1'b0, late_drop};

      case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_RUN:  if (instr_req_o && !instr_gnt_i) state_d = ST_HOLD;
         ST_HOLD: if (instr_gnt_i) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase

      if (instr_req_o && !instr_gnt_i) begin
         hold_addr_d  = instr_addr_o;
         hold_redir_d = ((state_q == ST_HOLD) && hold_redir_q) || redirect_i;
      end

      if (redirect_i) begin
         fetch_pc_d = {redirect_addr_i[31:2], 2'b00};
         // Everything still in flight after this cycle is stale, including a
         // request granted right now (it was issued to the old stream).
         discard_d  = out_cnt_q - {1'b0, instr_rvalid_i} + {1'b0, granted};
      end else if (granted && !((state_q == ST_HOLD) && hold_redir_q)) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
   end

   // IF/ID FIFO; a redirect flushes it ahead of any push or pop.
   always_comb begin
      fifo_cnt_d   = fifo_cnt_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      fifo_instr_d = fifo_instr_q;
      fifo_pc_d    = fifo_pc_q;

      if (redirect_i) begin
         fifo_cnt_d = 2'd0;
         rd_ptr_d   = 1'b0;
         wr_ptr_d   = 1'b0;
      end else begin
         if (push) begin
            fifo_instr_d[wr_ptr_q] = instr_rdata_i;
            fifo_pc_d[wr_ptr_q]    = push_pc;
            wr_ptr_d               = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         fetch_pc_q      <= BOOT_ADDR;
         hold_addr_q     <= BOOT_ADDR;
         hold_redir_q    <= 1'b0;
         out_cnt_q       <= 2'd0;
         discard_q       <= 2'd0;
         fifo_cnt_q      <= 2'd0;
         rd_ptr_q        <= 1'b0;
         wr_ptr_q        <= 1'b0;
         fifo_instr_q[0] <= 32'd0;
         fifo_instr_q[1] <= 32'd0;
         fifo_pc_q[0]    <= 32'd0;
         fifo_pc_q[1]    <= 32'd0;
      end else begin
         state_q         <= state_d;
         fetch_pc_q      <= fetch_pc_d;
         hold_addr_q     <= hold_addr_d;
         hold_redir_q    <= hold_redir_d;
         out_cnt_q       <= out_cnt_d;
         discard_q       <= discard_d;
         fifo_cnt_q      <= fifo_cnt_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         fifo_instr_q    <= fifo_instr_d;
         fifo_pc_q       <= fifo_pc_d;
      end
   end

`ifndef SYNTHESIS
   // The credit rule keeps a full FIFO from ever receiving a response.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(push && (fifo_cnt_q == 2'd2)));
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_panda_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_panda_if_stage
//  Purpose  : Scoreboard bench for panda_if_stage. A memory model grants and
//             answers requests in order; directed scenarios push hand-computed
//             expected IF/ID entries and request addresses into queues that
//             independent monitor processes pop and compare.
//  Revision : 1.0  initial release
// ============================================================================
module tb_panda_if_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_addr_i;
   logic        ready_i;
   logic        valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [31:0] pc_inc_o;

   panda_if_stage #(.BOOT_ADDR(32'h0000_0000)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .instr_req_o     (instr_req_o),
      .instr_addr_o    (instr_addr_o),
      .instr_gnt_i     (instr_gnt_i),
      .instr_rvalid_i  (instr_rvalid_i),
      .instr_rdata_i   (instr_rdata_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .ready_i         (ready_i),
      .valid_o         (valid_o),
      .instr_o         (instr_o),
      .pc_o            (pc_o),
      .pc_inc_o        (pc_inc_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_inc;
   } sb_t;

   sb_t         sb_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] pend_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          grant_cnt = 0;
   logic        gnt_ctrl  = 1'b0;
   logic        rvalid_en = 1'b1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   // Memory model: in-order, rvalid one cycle after grant when enabled.
   initial begin
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'd0;
      forever begin
         @(negedge clk_i);
         #1;
         if (rst_i) begin
            pend_q.delete();
            instr_gnt_i    = 1'b0;
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = 32'd0;
         end else begin
            if (rvalid_en && (pend_q.size() > 0)) begin
               instr_rvalid_i = 1'b1;
               instr_rdata_i  = mem_word(pend_q.pop_front());
            end else begin
               instr_rvalid_i = 1'b0;
               instr_rdata_i  = 32'd0;
            end
            instr_gnt_i = gnt_ctrl;
         end
         #1;
         if (!rst_i && instr_req_o && instr_gnt_i) begin
            pend_q.push_back(instr_addr_o);
            grant_cnt++;
            if (exp_addr_q.size() > 0) chk("req_addr", instr_addr_o, exp_addr_q.pop_front());
         end
      end
   end

   // IF/ID monitor: every accepted entry must match the scoreboard head.
   initial begin
      sb_t e;
      forever begin
         @(negedge clk_i);
         #3;
         if (!rst_i && valid_o && ready_i && !redirect_i) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected actual_pc=%h required=none", pc_o);
            end else begin
               e = sb_q.pop_front();
               chk("sb_pc", pc_o, e.pc);
               chk("sb_pc_inc", pc_inc_o, e.pc_inc);
               chk("sb_instr", instr_o, mem_word(e.pc));
            end
         end
      end
   end

   task automatic sb_push(input logic [31:0] pc, input logic [31:0] pc_inc);
      sb_t e;
      e.pc     = pc;
      e.pc_inc = pc_inc;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      rst_i           = 1'b1;
      ready_i         = 1'b0;
      redirect_i      = 1'b0;
      redirect_addr_i = 32'd0;
      gnt_ctrl        = 1'b0;
      rvalid_en       = 1'b1;
      repeat (2) tick();
      grant_cnt = 0;
      rst_i     = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && sb_q.size() > 0; i++) tick();
      chk(name, sb_q.size(), 0);
      ready_i = 1'b0;
   endtask

   initial begin
      // Reset state
      do_reset();
      rst_i = 1'b1;
      tick();
      #3;
      chk("rst_req", instr_req_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_pc", pc_o, 0);
      chk("rst_pc_inc", pc_inc_o, 0);

      // Sequential fetch with grant and ready always high
      do_reset();
      ready_i  = 1'b1;
      gnt_ctrl = 1'b1;
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      sb_push(32'h0, 32'h4);
      sb_push(32'h4, 32'h8);
      sb_push(32'h8, 32'hC);
      sb_push(32'hC, 32'h10);
      tick(); #3;
      chk("s1_req0", instr_req_o, 1);
      chk("s1_addr0", instr_addr_o, 32'h0);
      tick(); #3;
      chk("s1_addr1", instr_addr_o, 32'h4);
      chk("s1_valid_n1", valid_o, 0);
      tick(); #3;
      chk("s1_valid_n2", valid_o, 1);
      chk("s1_pc_n2", pc_o, 32'h0);
      drain("s1_drain");

      // ID stalled: at most two requests, FIFO holds 0x0 then 0x4
      do_reset();
      gnt_ctrl = 1'b1;
      exp_addr_q = '{32'h0, 32'h4};
      repeat (10) tick();
      #3;
      chk("s2_grants", grant_cnt, 2);
      chk("s2_req_low", instr_req_o, 0);
      chk("s2_valid", valid_o, 1);
      chk("s2_head_pc", pc_o, 32'h0);
      exp_addr_q = '{32'h8, 32'hC};
      sb_push(32'h0, 32'h4);
      sb_push(32'h4, 32'h8);
      sb_push(32'h8, 32'hC);
      sb_push(32'hC, 32'h10);
      tick();
      ready_i = 1'b1;
      drain("s2_drain");

      // Redirect with two requests outstanding
      do_reset();
      gnt_ctrl  = 1'b1;
      rvalid_en = 1'b0;
      exp_addr_q = '{32'h0, 32'h4, 32'h100, 32'h104};
      repeat (4) tick();
      #3;
      chk("s3_grants", grant_cnt, 2);
      chk("s3_req_low", instr_req_o, 0);
      tick();
      redirect_i      = 1'b1;
      redirect_addr_i = 32'h0000_0103;
      tick();
      redirect_i = 1'b0;
      rvalid_en  = 1'b1;
      #3;
      chk("s3_valid_flushed", valid_o, 0);
      sb_push(32'h100, 32'h104);
      ready_i = 1'b1;
      drain("s3_drain");

      // Grant withheld for three cycles, redirect in the second
      do_reset();
      ready_i  = 1'b1;
      gnt_ctrl = 1'b1;
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h200};
      sb_push(32'h0, 32'h4);
      sb_push(32'h4, 32'h8);
      for (int i = 0; i < 20 && grant_cnt < 2; i++) tick();
      gnt_ctrl = 1'b0;
      chk("s4_two_grants", grant_cnt, 2);
      for (int i = 0; i < 20 && !(instr_req_o && instr_addr_o == 32'h8); i++) tick();
      #3;
      chk("s4_hold1_addr", instr_addr_o, 32'h8);
      tick();
      redirect_i      = 1'b1;
      redirect_addr_i = 32'h0000_0200;
      #3;
      chk("s4_hold2_req", instr_req_o, 1);
      chk("s4_hold2_addr", instr_addr_o, 32'h8);
      tick();
      redirect_i = 1'b0;
      #3;
      chk("s4_hold3_addr", instr_addr_o, 32'h8);
      tick();
      gnt_ctrl = 1'b1;
      #3;
      chk("s4_grant_addr", instr_addr_o, 32'h8);
      sb_push(32'h200, 32'h204);
      drain("s4_drain");

      // Redirect granted in the same hold cycle, target at the top of memory
      do_reset();
      exp_addr_q = '{32'h0, 32'hFFFF_FFFC, 32'h0};
      tick();
      tick();
      tick();
      gnt_ctrl        = 1'b1;
      redirect_i      = 1'b1;
      redirect_addr_i = 32'hFFFF_FFFC;
      #3;
      chk("s5_held_addr", instr_addr_o, 32'h0);
      tick();
      redirect_i = 1'b0;
      sb_push(32'hFFFF_FFFC, 32'h0);
      sb_push(32'h0, 32'h4);
      ready_i = 1'b1;
      drain("s5_drain");

      // Redirect flushes a full FIFO
      do_reset();
      gnt_ctrl = 1'b1;
      repeat (6) tick();
      #3;
      chk("s6_full_valid", valid_o, 1);
      chk("s6_full_pc", pc_o, 32'h0);
      tick();
      redirect_i      = 1'b1;
      redirect_addr_i = 32'h0000_0040;
      exp_addr_q = '{32'h40};
      tick();
      redirect_i = 1'b0;
      #3;
      chk("s6_flushed", valid_o, 0);
      sb_push(32'h40, 32'h44);
      ready_i = 1'b1;
      drain("s6_drain");

      // Asynchronous reset between edges
      do_reset();
      gnt_ctrl = 1'b1;
      repeat (5) tick();
      #3;
      chk("s7_valid_before", valid_o, 1);
      #1;
      rst_i = 1'b1;
      #1;
      chk("s7_valid_async", valid_o, 0);
      chk("s7_req_async", instr_req_o, 0);
      tick();
      tick();
      rst_i = 1'b0;
      exp_addr_q = '{32'h0};
      tick();
      #3;
      chk("s7_req_after", instr_req_o, 1);
      chk("s7_addr_after", instr_addr_o, 32'h0);
      repeat (3) tick();
      chk("addr_queue_empty", exp_addr_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/panda_if_stage.md
PANDA_IF_STAGE -- requirements
Module: panda_if_stage

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 Port instr_req_o  output  1  instruction memory request.
REQ-005 Port instr_addr_o  output  32  request address, word-aligned.
REQ-006 Port instr_gnt_i  input  1  request accepted this cycle.
REQ-007 Port instr_rvalid_i  input  1  response valid; responses return in request order.
REQ-008 Port instr_rdata_i  input  32  response instruction word.
REQ-009 Port redirect_i  input  1  branch/jump taken in EX; flush and refetch.
REQ-010 Port redirect_addr_i  input  32  new fetch target.
REQ-011 Port ready_i  input  1  ID stage accepts the current IF/ID entry.
REQ-012 Port valid_o  output  1  IF/ID entry valid.
REQ-013 Port instr_o  output  32  instr field of IF/ID register.
REQ-014 Port pc_o  output  32  pc field of IF/ID register.
REQ-015 Port pc_inc_o  output  32  pc_o + 4, modulo 2^32.

Function
REQ-016 The stage SHALL contain a fetch PC register, a 2-entry FIFO of {instr, pc}, an outstanding-request counter (0..2), and a discard counter (0..2).
REQ-017 The FSM SHALL have states IDLE, RUN, HOLD; IDLE is the reset state and SHALL go to RUN unconditionally on the first clock edge after rst_i deasserts.
REQ-018 In RUN, instr_req_o SHALL be 1 iff outstanding + fifo_count < 2 (registered values, no same-cycle pop credit), with instr_addr_o = fetch PC.
REQ-019 On instr_req_o && instr_gnt_i, fetch PC SHALL advance by 4 (wrapping) and outstanding SHALL increment.
REQ-020 On instr_req_o && !instr_gnt_i, the FSM SHALL enter HOLD; in HOLD, instr_req_o SHALL stay 1 and instr_addr_o stable until grant, then return to RUN.
REQ-021 On instr_rvalid_i, outstanding SHALL decrement; if discard > 0, discard SHALL decrement and the data SHALL be dropped, else {instr_rdata_i, pc of that request} SHALL be written to the FIFO.
REQ-022 valid_o SHALL equal FIFO non-empty; instr_o/pc_o SHALL show the FIFO head; pop SHALL occur on valid_o && ready_i.
REQ-023 Minimum latency: grant in cycle N, rvalid in N+1, valid_o in N+2.
REQ-024 On redirect_i: FIFO SHALL be flushed (valid_o = 0 next cycle), discard SHALL be set to the count of outstanding requests not returning this cycle, and fetch PC SHALL load {redirect_addr_i[31:2], 2'b00}.
REQ-025 A redirect in HOLD SHALL NOT change instr_addr_o; the held request completes and its response SHALL be discarded; the target issues after grant.
REQ-026 A redirect in HOLD that is granted in the same cycle SHALL count that request as discarded.
REQ-027 Redirect SHALL take priority over push and pop in the same cycle; no data from before the redirect SHALL ever reach valid_o.
REQ-028 Simultaneous push and pop with FIFO full SHALL be impossible by the credit rule (REQ-018); push to a full FIFO is a design error and SHALL be asserted against.
REQ-029 Fetch PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.

Reset
REQ-030 While rst_i = 1: state IDLE, fetch PC = BOOT_ADDR, FIFO empty, counters 0, instr_req_o = 0, valid_o = 0, instr_o/pc_o/pc_inc_o = 0.
REQ-031 Reset asserted mid-operation SHALL clear all state immediately; responses arriving after reset release for pre-reset requests are out of protocol and not handled.

Verification
REQ-032 Reset release, gnt=1 always, rvalid one cycle later, ready_i=1 -> addresses 0x0,0x4,0x8... issued back-to-back; valid_o high with pc_o 0x0 two cycles after first grant.
REQ-033 ready_i=0 for 10 cycles -> at most 2 requests in flight/buffered, instr_req_o drops; FIFO holds pc 0x0,0x4 in order; resumes on ready_i=1.
REQ-034 redirect_i=1, redirect_addr_i=0x103 with 2 outstanding -> both responses dropped, next request addr 0x100, next valid_o pc_o = 0x100, pc_inc_o = 0x104.
REQ-035 gnt=0 for 3 cycles with redirect to 0x200 in the second -> addr stays 0x8 until grant, its data discarded, next issued addr 0x200.
REQ-036 Fetch PC at 0xFFFF_FFFC -> following request addr 0x0, pc_inc_o for that entry = 0x0.
REQ-037 rst_i asserted asynchronously between clock edges with valid_o=1 -> valid_o and instr_req_o 0 immediately; after release, first request addr = BOOT_ADDR.
